// File: rtl/temp_avg_sched_if.sv
// Handshake and data bundle between the sensor bus and the averaging controller.
interface temp_avg_sched_if #(
    parameter int S_NR       = 8,
    parameter int TEMP_WIDTH = 5,
    parameter int T_MIN      = 19,
    parameter int T_MAX      = 26
);
    logic                         start;
    logic [S_NR*TEMP_WIDTH-1:0]   value;
    logic [S_NR-1:0]              enable;
    logic                         busy;
    logic                         done;
    logic [2*TEMP_WIDTH-1:0]      avg;
    logic [T_MAX-T_MIN:0]         led_output;
    logic                         alert;

    modport master (
        output start, value, enable,
        input  busy, done, avg, led_output, alert
    );

    modport slave (
        input  start, value, enable,
        output busy, done, avg, led_output, alert
    );
endinterface

// File: rtl/temp_avg_sched.sv
// Time-multiplexed average of enabled sensors with LED bar and alert.
// Optional round-half-up of the average: define TEMP_AVG_ROUND_EN.
module temp_avg_sched #(
    parameter int S_NR       = 8,
    parameter int TEMP_WIDTH = 5,
    parameter int T_MIN      = 19,
    parameter int T_MAX      = 26
) (
    input  logic              clk,
    input  logic              rst_n,
    temp_avg_sched_if.slave   bus
);
    localparam int AW   = 2*TEMP_WIDTH;
    localparam int LW   = T_MAX - T_MIN + 1;
    localparam int IMAX = (S_NR > AW) ? S_NR : AW;
    localparam int IW   = $clog2(IMAX + 1);
    localparam logic [AW-1:0] T_MIN_V = AW'(T_MIN);
    localparam logic [AW-1:0] T_MAX_V = AW'(T_MAX);
    localparam logic [AW-1:0] ONE_A   = AW'(1);
    localparam logic [IW-1:0] ONE_I   = IW'(1);

    typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, FINISH} state_t;

    state_t                     state;
    state_t                     state_next;
    logic [S_NR*TEMP_WIDTH-1:0] value_sh;
    logic [S_NR-1:0]            enable_sh;
    logic [AW-1:0]              sum;
    logic [AW-1:0]              count;
    logic [AW-1:0]              rem;
    logic [IW-1:0]              idx;

    logic                       accum_last;
    logic                       div_last;
    logic [AW:0]                trial;
    logic                       qbit;
    logic [AW-1:0]              rem_next;
    logic [AW-1:0]              avg_calc;
    logic [AW-1:0]              offset;
    logic [AW-1:0]              avg_next;
    logic [LW-1:0]              led_next;
    logic                       alert_next;

    assign accum_last = (idx == IW'(S_NR - 1));
    assign div_last   = (idx == IW'(AW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = ACCUM;
            ACCUM:   if (accum_last) state_next = DIVIDE;
            DIVIDE:  if (div_last) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // During DIVIDE the sum register shifts out the dividend and shifts in quotient bits.
    always_comb begin
        bus.busy   = (state != IDLE) || bus.done;
        trial      = {rem, sum[AW-1]};
        qbit       = (trial >= {1'b0, count});
        rem_next   = qbit ? (trial[AW-1:0] - count) : trial[AW-1:0];
`ifdef TEMP_AVG_ROUND_EN
        avg_calc   = ({rem, 1'b0} >= {1'b0, count}) ? (sum + ONE_A) : sum;
`else
        avg_calc   = sum;
`endif
        offset     = avg_calc - T_MIN_V;
        avg_next   = avg_calc;
        led_next   = '0;
        alert_next = 1'b0;
        if (count == '0) begin
            avg_next = '0;
        end else if (avg_calc < T_MIN_V) begin
            alert_next = 1'b1;
        end else if (avg_calc > T_MAX_V) begin
            led_next   = '1;
            alert_next = 1'b1;
        end else begin
            for (int i = 0; i < LW; i++) led_next[i] = (offset >= AW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_sh       <= '0;
            enable_sh      <= '0;
            sum            <= '0;
            count          <= '0;
            rem            <= '0;
            idx            <= '0;
            bus.done       <= 1'b0;
            bus.avg        <= '0;
            bus.led_output <= '0;
            bus.alert      <= 1'b0;
        end else begin
            bus.done <= (state == FINISH);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        value_sh  <= bus.value;
                        enable_sh <= bus.enable;
                        sum       <= '0;
                        count     <= '0;
                        rem       <= '0;
                        idx       <= '0;
                    end
                end
                ACCUM: begin
                    if (enable_sh[0]) begin
                        sum   <= sum + {{(AW-TEMP_WIDTH){1'b0}}, value_sh[TEMP_WIDTH-1:0]};
                        count <= count + ONE_A;
                    end
                    value_sh  <= value_sh >> TEMP_WIDTH;
                    enable_sh <= enable_sh >> 1;
                    idx       <= accum_last ? '0 : idx + ONE_I;
                end
                DIVIDE: begin
                    sum <= {sum[AW-2:0], qbit};
                    rem <= rem_next;
                    idx <= idx + ONE_I;
                end
                FINISH: begin
                    bus.avg        <= avg_next;
                    bus.led_output <= led_next;
                    bus.alert      <= alert_next;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_temp_avg_sched.sv
// Scoreboard bench for temp_avg_sched: directed runs, latency, mid-run noise, held start, reset abort.
module tb_temp_avg_sched;
    typedef struct packed {
        logic [9:0] avg;
        logic [7:0] led;
        logic       alert;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   start_cyc;
    int   tests;
    int   fails;
    exp_t exp_q[$];

    temp_avg_sched_if #(.S_NR(8), .TEMP_WIDTH(5), .T_MIN(19), .T_MAX(26)) bus ();

    temp_avg_sched #(.S_NR(8), .TEMP_WIDTH(5), .T_MIN(19), .T_MAX(26)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [39:0] lanes(input int v0, input int v1, input int v2, input int v3,
                                          input int v4, input int v5, input int v6, input int v7);
        return {5'(v7), 5'(v6), 5'(v5), 5'(v4), 5'(v3), 5'(v2), 5'(v1), 5'(v0)};
    endfunction

    // Reference: integer average of enabled lanes mapped onto the 19..26 bar.
    function automatic exp_t model(input logic [39:0] vals, input logic [7:0] en);
        exp_t e;
        int s, c, q;
        s = 0;
        c = 0;
        for (int k = 0; k < 8; k++) begin
            if (en[k]) begin
                s += int'(vals[k*5 +: 5]);
                c++;
            end
        end
        e = '0;
        if (c != 0) begin
            q = s / c;
`ifdef TEMP_AVG_ROUND_EN
            if (2 * (s % c) >= c) q++;
`endif
            e.avg = 10'(q);
            if (q < 19) begin
                e.alert = 1'b1;
            end else if (q > 26) begin
                e.led   = 8'hFF;
                e.alert = 1'b1;
            end else begin
                e.led = 8'((1 << (q - 18)) - 1);
            end
        end
        return e;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic driveStart(input logic [39:0] vals, input logic [7:0] en, input bit hold);
        @(negedge clk);
        bus.value  = vals;
        bus.enable = en;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        if (!hold) bus.start = 1'b0;
    endtask

    task automatic applyStimulus(input logic [39:0] vals, input logic [7:0] en);
        exp_q.push_back(model(vals, en));
        driveStart(vals, en, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input bit expect_idle);
        exp_t e;
        do begin
            @(posedge clk);
            #1;
        end while (!bus.done && (cyc - start_cyc) < 40);
        checkVal({tag, "_latency"}, 32'(cyc - start_cyc), 32'd19);
        checkVal({tag, "_busy_at_done"}, 32'(bus.busy), 32'd1);
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("[TB] FAIL %s_scoreboard: observed empty queue expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            checkVal({tag, "_avg"}, 32'(bus.avg), 32'(e.avg));
            checkVal({tag, "_led"}, 32'(bus.led_output), 32'(e.led));
            checkVal({tag, "_alert"}, 32'(bus.alert), 32'(e.alert));
            if (expect_idle) begin
                @(posedge clk);
                #1;
                checkVal({tag, "_done_drop"}, 32'(bus.done), 32'd0);
                checkVal({tag, "_busy_drop"}, 32'(bus.busy), 32'd0);
                checkVal({tag, "_avg_hold"}, 32'(bus.avg), 32'(e.avg));
            end
        end
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        start_cyc  = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.value  = '0;
        bus.enable = '0;
        repeat (3) @(posedge clk);
        #1;
        checkVal("reset_avg", 32'(bus.avg), 32'd0);
        checkVal("reset_led", 32'(bus.led_output), 32'd0);
        checkVal("reset_alert", 32'(bus.alert), 32'd0);
        checkVal("reset_busy", 32'(bus.busy), 32'd0);
        checkVal("reset_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(lanes(22, 22, 22, 22, 22, 22, 22, 22), 8'hFF);
        checkVal("all22_busy_after_start", 32'(bus.busy), 32'd1);
        checkOutput("all22", 1'b1);

        applyStimulus(lanes(20, 21, 24, 31, 31, 31, 31, 31), 8'h07);
        checkOutput("three", 1'b1);

        applyStimulus(lanes(30, 31, 5, 5, 5, 5, 5, 5), 8'h03);
        checkOutput("hot", 1'b1);

        applyStimulus(lanes(31, 31, 31, 31, 10, 31, 31, 31), 8'h10);
        checkOutput("cold_single", 1'b1);

        applyStimulus(lanes(31, 31, 31, 31, 31, 31, 31, 31), 8'h00);
        checkOutput("none", 1'b1);

        // Inputs and start toggled mid-run must not disturb the sampled computation.
        applyStimulus(lanes(25, 25, 25, 25, 25, 25, 25, 25), 8'hFF);
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.value  = lanes(5, 5, 5, 5, 5, 5, 5, 5);
        bus.enable = 8'h01;
        bus.start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        checkVal("midrun_busy", 32'(bus.busy), 32'd1);
        checkOutput("midrun", 1'b1);

        // Held start: the second run samples the inputs present when it is accepted.
        exp_q.push_back(model(lanes(20, 21, 24, 0, 0, 0, 0, 0), 8'h07));
        exp_q.push_back(model(lanes(26, 26, 26, 26, 26, 26, 26, 26), 8'hFF));
        driveStart(lanes(20, 21, 24, 0, 0, 0, 0, 0), 8'h07, 1'b1);
        @(negedge clk);
        bus.value  = lanes(26, 26, 26, 26, 26, 26, 26, 26);
        bus.enable = 8'hFF;
        checkOutput("held_a", 1'b0);
        start_cyc = cyc + 1;
        checkOutput("held_b", 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        checkVal("held_idle_busy", 32'(bus.busy), 32'd0);

        // Reset during DIVIDE abandons the run and clears outputs without a clock edge.
        driveStart(lanes(12, 12, 12, 12, 12, 12, 12, 12), 8'hFF, 1'b0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkVal("abort_avg", 32'(bus.avg), 32'd0);
        checkVal("abort_led", 32'(bus.led_output), 32'd0);
        checkVal("abort_alert", 32'(bus.alert), 32'd0);
        checkVal("abort_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(lanes(22, 22, 22, 22, 22, 22, 22, 22), 8'hFF);
        checkOutput("after_abort", 1'b1);

        checkVal("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
